// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the ROM word address, tags each fetched
// word with its PC and buffers it in a 2-entry FIFO toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0033;

    logic [31:0] fetch_pc;
    logic [31:0] pc_q   [2];
    logic [31:0] word_q [2];
    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push;
    logic        pop;

    // Word address wraps naturally by truncation; inst_pc keeps the full PC.
    assign imem_addr  = fetch_pc[ADDR_W+1:2];

    assign inst       = word_q[rd_ptr];
    assign inst_pc    = pc_q[rd_ptr];
    assign inst_valid = (count != 2'd0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign push       = !redirect_valid && ((count < 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC_ALIGNED;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= 32'h0;
                word_q[i] <= NOP_WORD;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]   <= fetch_pc;
                word_q[wr_ptr] <= imem_data;
                wr_ptr         <= ~wr_ptr;
                fetch_pc       <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirects,
// reset priority and word-address wrap on a second instance.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic [15:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return (a == 16'd4) ? 32'h3020_0073 : 32'h0000_0033;
    endfunction

    assign imem_data   = rom_word(imem_addr);
    assign w_imem_data = rom_word(w_imem_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(32'h0003_FFFC), .ADDR_W(16)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_inst_valid), .inst_ready(1'b1),
        .inst(w_inst), .inst_pc(w_inst_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, apply inputs, let combinational outputs settle.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] w);
        check({tag, "_valid"}, {31'h0, inst_valid}, {31'h0, v});
        check({tag, "_pc"}, inst_pc, pc);
        check({tag, "_inst"}, inst, w);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;

        // Reset state and sequential fetch
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check_head("rst", 0, 32'h0, 32'h33);
        check("rst_addr", {16'h0, imem_addr}, 32'h0);
        step(0, 0, 0, 1);
        check_head("c1", 0, 32'h0, 32'h33);
        check("c1_addr", {16'h0, imem_addr}, 32'h0);
        step(0, 0, 0, 1);
        check_head("seq0", 1, 32'h0, 32'h33);
        check("seq0_addr", {16'h0, imem_addr}, 32'h1);
        step(0, 0, 0, 1);
        check_head("seq4", 1, 32'h4, 32'h33);
        step(0, 0, 0, 1);
        check_head("seq8", 1, 32'h8, 32'h33);
        step(0, 0, 0, 1);
        check_head("seqC", 1, 32'hC, 32'h33);
        step(0, 0, 0, 1);
        check_head("seq10", 1, 32'h10, 32'h3020_0073);
        check("seq10_addr", {16'h0, imem_addr}, 32'h5);

        // Backpressure
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check_head("bp_first", 1, 32'h0, 32'h33);
        step(0, 0, 0, 0);
        check_head("bp_c3", 1, 32'h4, 32'h33);
        check("bp_c3_addr", {16'h0, imem_addr}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            check_head("bp_hold", 1, 32'h4, 32'h33);
            check("bp_hold_addr", {16'h0, imem_addr}, 32'h3);
        end
        step(0, 0, 0, 1);
        check_head("bp_rel4", 1, 32'h4, 32'h33);
        step(0, 0, 0, 1);
        check_head("bp_rel8", 1, 32'h8, 32'h33);
        step(0, 0, 0, 1);
        check_head("bp_relC", 1, 32'hC, 32'h33);

        // Redirect with a full buffer
        step(0, 1, 32'h10, 1);
        check("redir_valid", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 0, 1);
        check("redir_addr", {16'h0, imem_addr}, 32'h4);
        check("redir_empty", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 0, 1);
        check_head("redir_head", 1, 32'h10, 32'h3020_0073);

        // Misaligned redirect, then let the FIFO fill
        step(0, 1, 32'h13, 1);
        check("mis_valid", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 0, 1);
        check("mis_addr", {16'h0, imem_addr}, 32'h4);
        step(0, 0, 0, 0);
        check_head("mis_head", 1, 32'h10, 32'h3020_0073);

        // Redirect held two cycles; only the last target counts
        step(0, 1, 32'h8, 0);
        check("multi1_valid", {31'h0, inst_valid}, 32'h0);
        step(0, 1, 32'hC, 0);
        check("multi2_valid", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 0, 0);
        check("multi_addr", {16'h0, imem_addr}, 32'h3);
        check("multi_empty", {31'h0, inst_valid}, 32'h0);
        step(0, 0, 0, 0);
        check_head("multi_head", 1, 32'hC, 32'h33);
        step(0, 0, 0, 0);
        check_head("multi_full", 1, 32'hC, 32'h33);
        check("multi_full_addr", {16'h0, imem_addr}, 32'h5);

        // Reset beats redirect and ready on a full buffer
        step(1, 1, 32'h8, 1);
        step(0, 0, 0, 1);
        check_head("rprio", 0, 32'h0, 32'h33);
        check("rprio_addr", {16'h0, imem_addr}, 32'h0);
        check("wrap_addr0", {16'h0, w_imem_addr}, 32'hFFFF);
        check("wrap_v0", {31'h0, w_inst_valid}, 32'h0);
        step(0, 0, 0, 1);
        check_head("rprio_next", 1, 32'h0, 32'h33);
        check("wrap_addr1", {16'h0, w_imem_addr}, 32'h0);
        check("wrap_v1", {31'h0, w_inst_valid}, 32'h1);
        check("wrap_pc0", w_inst_pc, 32'h0003_FFFC);
        step(0, 0, 0, 1);
        check("wrap_pc1", w_inst_pc, 32'h0004_0000);
        check("wrap_inst1", w_inst, 32'h33);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RISCV-Lite core, and the requesting side of the instruction ROM interface. It drives a word address to the combinational instruction memory and captures the 32-bit word returned in the same cycle. Each fetched word is tagged with its PC and buffered in a 2-entry FIFO. Entries are delivered to decode over a valid/ready handshake, and the buffer is flushed on branch, jump or trap-return redirects.

## Interface
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.
- ADDR_W, 16: width of the word address driven to instruction memory.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  word address to ROM; equals fetch_pc[ADDR_W+1:2]; combinational from fetch_pc.
- imem_data  in  32  ROM read data; valid in the same cycle as imem_addr.
- redirect_valid  in  1  flush-and-redirect request from execute (branch, jump, mret).
- redirect_pc  in  32  redirect target byte address.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst  out  32  instruction word at the buffer head.
- inst_pc  out  32  byte PC of inst.

## Operation
- State:
  - fetch_pc: 32-bit, word-aligned.
  - FIFO: 2 entries of {pc[31:0], word[31:0]}.
  - count: 0..2.
  - Read/write pointers: 1 bit each.
- Buffer is not forwarded combinationally. inst and inst_pc always come from the FIFO head. Unoccupied head reads as the last written or reset value.
- inst_valid = (count != 0) && !redirect_valid.
- pop = inst_valid && inst_ready.
- push = !redirect_valid && (count < 2 || pop). Full with simultaneous pop still pushes.
- On push:
  - Write {fetch_pc, imem_data} at the write pointer.
  - fetch_pc <= fetch_pc + 4, modulo 2^32.
- No push means fetch_pc holds, so imem_addr is stable under backpressure.
- count update:
  - count + 1 on push only.
  - count − 1 on pop only.
  - Unchanged when both or neither occur.
- Redirect (redirect_valid=1), priority over push and pop:
  - count <= 0; both pointers <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}. Low two bits are silently dropped.
  - No handshake completes in this cycle.
- Reset, priority over redirect, push and pop:
  - fetch_pc <= RESET_PC with low 2 bits cleared.
  - count and pointers <= 0.
  - Both FIFO entries <= {32'h0, 32'h00000033}, i.e. a NOP word.
- Address wrap:
  - imem_addr wraps modulo 2^ADDR_W words.
  - inst_pc keeps the full 32-bit PC.
  - No error is flagged on wrap.

## Timing
- Output values while rst=1 and in the first cycle after release:
  - inst_valid=0.
  - inst=32'h00000033, inst_pc=0.
  - imem_addr=RESET_PC[ADDR_W+1:2].
- Fetch-to-valid latency:
  - A word addressed in cycle N appears at the head no earlier than cycle N+1.
  - First instruction after reset release: inst_valid=1 in the 2nd cycle after rst deasserts.
- Throughput: 1 instruction per cycle with inst_ready held high; no bubbles in steady state.
- Redirect latency:
  - Redirect asserted in cycle N gives imem_addr = target in cycle N+1.
  - The target instruction is valid at the head in cycle N+2.
- Redirect held for multiple cycles: each cycle re-flushes and reloads fetch_pc; no pushes occur.
- Backpressure:
  - The FIFO fills within 2 cycles of inst_ready going low.
  - inst, inst_pc and inst_valid stay stable while inst_valid=1 and inst_ready=0.

## Test plan
- Sequential fetch:
  - Stimulus: RESET_PC=0; ROM words 0..6 = 00000033 ×4, 30200073, 00000033 ×2; inst_ready=1.
  - Required: inst_valid rises 2 cycles after reset release. Accepted (inst_pc, inst) pairs are (0,00000033), (4,00000033), (8,00000033), (0xC,00000033), (0x10,30200073), one per cycle.
- Backpressure:
  - Stimulus: after the first accept, hold inst_ready=0 for 5 cycles, then release.
  - Required: count saturates at 2; imem_addr holds at 3; the head stays (4,00000033). After release, accepted PCs are 4, 8, 0xC with no gaps or duplicates.
- Redirect with full buffer:
  - Stimulus: FIFO full, redirect_valid=1 with redirect_pc=0x10 for one cycle.
  - Required: inst_valid=0 in that cycle; imem_addr=4 next cycle; head = (0x10,30200073) the cycle after that.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x13.
  - Required: imem_addr=4; inst_pc=0x10.
- Wrap-around:
  - Stimulus: RESET_PC=0x3FFFC, ADDR_W=16.
  - Required: imem_addr goes 0xFFFF then 0x0000; inst_pc goes 0x3FFFC then 0x40000.
- Reset priority:
  - Stimulus: assert rst together with redirect_valid and inst_ready while the FIFO is full.
  - Required: next cycle count=0, inst_valid=0, imem_addr=RESET_PC word, inst=00000033, inst_pc=0.
